// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM->WB pipeline stage.
// Default field widths, the write-back payload layout and occupancy encodings.
package wb_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_REG_ADDR_W = 5;
  localparam int WB_PC_W       = 32;

  typedef struct packed {
    logic                     regwrite;
    logic [WB_DATA_W-1:0]     wdata;
    logic [WB_REG_ADDR_W-1:0] wreg;
    logic [WB_PC_W-1:0]       pc;
  } wb_payload_t;

  localparam int WB_PAYLOAD_W = $bits(wb_payload_t);

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/wb_pipe_stage_if.sv
// Handshake bus of the MEM->WB stage: upstream payload in, head payload out.
// The slave modport is the stage itself; the master modport is whoever drives it.
interface wb_pipe_stage_if
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int REG_ADDR_W = WB_REG_ADDR_W,
  parameter int PC_W       = WB_PC_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic                  regwrite_in;
  logic [DATA_W-1:0]     wdata_in;
  logic [REG_ADDR_W-1:0] wreg_in;
  logic [PC_W-1:0]       pc_in;
  logic                  out_valid;
  logic                  out_ready;
  logic                  regwrite_out;
  logic [DATA_W-1:0]     wdata_out;
  logic [REG_ADDR_W-1:0] wreg_out;
  logic [PC_W-1:0]       pc_out;
  logic [1:0]            occupancy;

  modport slave (
    input  in_valid, flush, regwrite_in, wdata_in, wreg_in, pc_in, out_ready,
    output in_ready, out_valid, regwrite_out, wdata_out, wreg_out, pc_out, occupancy
  );

  modport master (
    output in_valid, flush, regwrite_in, wdata_in, wreg_in, pc_in, out_ready,
    input  in_ready, out_valid, regwrite_out, wdata_out, wreg_out, pc_out, occupancy
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: head entry drives the outputs, skid entry catches
// one extra beat while the head stalls. in_ready is registered, so no comb path from out_ready.
module pipe_skid_buf
  import wb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit NEG_EDGE = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             clk_act;
  logic [WIDTH-1:0] head_reg, head_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  occ_t             occ_reg, occ_next;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             accept;
  logic             drain;

  // Falling-edge operation is an inverted clock, which maps onto the FF clock inverter.
  generate
    if (NEG_EDGE) begin : g_neg
      assign clk_act = ~Clk;
    end else begin : g_pos
      assign clk_act = Clk;
    end
  endgenerate

  assign accept = in_valid & in_ready_reg;
  assign drain  = out_valid_reg & out_ready;

  always_comb begin
    head_next = head_reg;
    skid_next = skid_reg;
    occ_next  = occ_reg;
    if (flush) begin
      occ_next = OCC_EMPTY;
    end else begin
      case (occ_reg)
        OCC_EMPTY: begin
          if (accept) begin
            head_next = in_data;
            occ_next  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            head_next = in_data;
          end else if (accept) begin
            skid_next = in_data;
            occ_next  = OCC_FULL;
          end else if (drain) begin
            occ_next  = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (drain) begin
            head_next = skid_reg;
            occ_next  = OCC_ONE;
          end
        end
        default: occ_next = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_act or posedge Reset) begin
    if (Reset) begin
      head_reg      <= '0;
      skid_reg      <= '0;
      occ_reg       <= OCC_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      head_reg      <= head_next;
      skid_reg      <= skid_next;
      occ_reg       <= occ_next;
      in_ready_reg  <= (occ_next != OCC_FULL);
      out_valid_reg <= (occ_next != OCC_EMPTY);
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = head_reg;
  assign occupancy = occ_reg;

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline register with valid/ready handshake, flush and register-0 write suppression.
// Packs the write-back fields into one word for the skid buffer and gates regwrite on the way out.
module wb_pipe_stage
  import wb_pkg::*;
#(
  parameter int DATA_W        = WB_DATA_W,
  parameter int REG_ADDR_W    = WB_REG_ADDR_W,
  parameter int PC_W          = WB_PC_W,
  parameter bit NEG_EDGE      = 1'b1,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input logic             Clk,
  input logic             Reset,
  wb_pipe_stage_if.slave  bus
);

  // Same field order as wb_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  regwrite;
    logic [DATA_W-1:0]     wdata;
    logic [REG_ADDR_W-1:0] wreg;
    logic [PC_W-1:0]       pc;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  payload_t in_p;
  payload_t out_p;
  logic     out_valid;
  logic     rw_capture;

  generate
    if (ZERO_SUPPRESS) begin : g_zs
      assign rw_capture = bus.regwrite_in & (bus.wreg_in != '0);
    end else begin : g_nozs
      assign rw_capture = bus.regwrite_in;
    end
  endgenerate

  assign in_p.regwrite = rw_capture;
  assign in_p.wdata    = bus.wdata_in;
  assign in_p.wreg     = bus.wreg_in;
  assign in_p.pc       = bus.pc_in;

  pipe_skid_buf #(
    .WIDTH    (PAYLOAD_W),
    .NEG_EDGE (NEG_EDGE)
  ) u_skid (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_p),
    .out_valid (out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_p),
    .occupancy (bus.occupancy)
  );

  // A stale head left behind by a drain or flush must never reach the register file.
  assign bus.out_valid    = out_valid;
  assign bus.regwrite_out = out_p.regwrite & out_valid;
  assign bus.wdata_out    = out_p.wdata;
  assign bus.wreg_out     = out_p.wreg;
  assign bus.pc_out       = out_p.pc;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage: falling-edge/zero-suppress instance checked by a
// FIFO scoreboard, plus a rising-edge instance without suppression.
module tb_wb_pipe_stage;
  import wb_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  wb_pipe_stage_if #(.DATA_W(WB_DATA_W), .REG_ADDR_W(WB_REG_ADDR_W), .PC_W(WB_PC_W)) m_if ();
  wb_pipe_stage_if #(.DATA_W(WB_DATA_W), .REG_ADDR_W(WB_REG_ADDR_W), .PC_W(WB_PC_W)) p_if ();

  wb_pipe_stage #(
    .DATA_W(WB_DATA_W), .REG_ADDR_W(WB_REG_ADDR_W), .PC_W(WB_PC_W),
    .NEG_EDGE(1'b1), .ZERO_SUPPRESS(1'b1)
  ) dut (.Clk(Clk), .Reset(Reset), .bus(m_if));

  wb_pipe_stage #(
    .DATA_W(WB_DATA_W), .REG_ADDR_W(WB_REG_ADDR_W), .PC_W(WB_PC_W),
    .NEG_EDGE(1'b0), .ZERO_SUPPRESS(1'b0)
  ) dut_pos (.Clk(Clk), .Reset(Reset), .bus(p_if));

  int          n_vec = 0;
  int          n_err = 0;
  wb_payload_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic wb_payload_t mk(input logic rw, input logic [31:0] wd,
                                     input logic [4:0] wr, input logic [31:0] pc);
    wb_payload_t p;
    p.regwrite = rw & (wr != 5'd0);
    p.wdata    = wd;
    p.wreg     = wr;
    p.pc       = pc;
    return p;
  endfunction

  task automatic set_in(input logic v, input logic rw, input logic [31:0] wd,
                        input logic [4:0] wr, input logic [31:0] pc);
    m_if.in_valid    = v;
    m_if.regwrite_in = rw;
    m_if.wdata_in    = wd;
    m_if.wreg_in     = wr;
    m_if.pc_in       = pc;
  endtask

  // One falling edge of the main instance: scoreboard drain check, then post-edge state check.
  task automatic cycle();
    bit          f;
    bit          acc;
    bit          drn;
    wb_payload_t inp;
    wb_payload_t e;
    f   = m_if.flush;
    acc = m_if.in_valid && (exp_q.size() < 2) && !f;
    drn = (exp_q.size() > 0) && m_if.out_ready && !f;
    inp = mk(m_if.regwrite_in, m_if.wdata_in, m_if.wreg_in, m_if.pc_in);
    if (drn) begin
      e = exp_q.pop_front();
      chk("drain_valid", m_if.out_valid, 1'b1);
      chk("drain_wdata", m_if.wdata_out, e.wdata);
      chk("drain_wreg", m_if.wreg_out, e.wreg);
      chk("drain_pc", m_if.pc_out, e.pc);
      chk("drain_regwrite", m_if.regwrite_out, e.regwrite);
      $display("tb: drain wdata=0x%0h wreg=%0d pc=0x%0h rw=%0b",
               m_if.wdata_out, m_if.wreg_out, m_if.pc_out, m_if.regwrite_out);
    end
    @(negedge Clk);
    #1;
    if (f) exp_q.delete();
    else if (acc) exp_q.push_back(inp);
    chk("occupancy", m_if.occupancy, exp_q.size());
    chk("in_ready", m_if.in_ready, exp_q.size() != 2);
    chk("out_valid", m_if.out_valid, exp_q.size() != 0);
    if (exp_q.size() == 0) begin
      chk("idle_regwrite", m_if.regwrite_out, 1'b0);
    end else begin
      chk("head_wdata", m_if.wdata_out, exp_q[0].wdata);
      chk("head_regwrite", m_if.regwrite_out, exp_q[0].regwrite);
    end
  endtask

  // Hold the beat until the model says it was taken (bounded), then drop in_valid.
  task automatic send(input logic rw, input logic [31:0] wd, input logic [4:0] wr,
                      input logic [31:0] pc);
    bit taken;
    set_in(1'b1, rw, wd, wr, pc);
    for (int k = 0; k < 8; k++) begin
      taken = (exp_q.size() < 2) && !m_if.flush;
      cycle();
      if (taken) break;
    end
    m_if.in_valid = 1'b0;
  endtask

  task automatic drain_all();
    m_if.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_occ"}, m_if.occupancy, 2'd0);
    chk({tag, "_in_ready"}, m_if.in_ready, 1'b1);
    chk({tag, "_out_valid"}, m_if.out_valid, 1'b0);
    chk({tag, "_regwrite"}, m_if.regwrite_out, 1'b0);
    chk({tag, "_wdata"}, m_if.wdata_out, 32'd0);
    chk({tag, "_wreg"}, m_if.wreg_out, 5'd0);
    chk({tag, "_pc"}, m_if.pc_out, 32'd0);
    chk({tag, "_pos_occ"}, p_if.occupancy, 2'd0);
  endtask

  initial begin
    set_in(1'b0, 1'b0, 32'd0, 5'd0, 32'd0);
    m_if.flush = 1'b0;  m_if.out_ready = 1'b0;
    p_if.in_valid = 1'b0; p_if.flush = 1'b0; p_if.out_ready = 1'b0;
    p_if.regwrite_in = 1'b0; p_if.wdata_in = '0; p_if.wreg_in = '0; p_if.pc_in = '0;

    #1 Reset = 1'b1;
    #2 chk_reset_state("por");
    #9 Reset = 1'b0;
    @(negedge Clk); #1;

    // In-order streaming with downstream always ready
    m_if.out_ready = 1'b1;
    send(1'b1, 32'h11, 5'd5, 32'h100);
    send(1'b1, 32'h22, 5'd5, 32'h104);
    send(1'b1, 32'h33, 5'd5, 32'h108);
    drain_all();

    // Stall: two beats fill the buffer, third waits upstream
    m_if.out_ready = 1'b0;
    send(1'b1, 32'hA, 5'd3, 32'h200);
    send(1'b1, 32'hB, 5'd4, 32'h204);
    set_in(1'b1, 1'b1, 32'hC, 5'd6, 32'h208);
    cycle();
    cycle();
    m_if.out_ready = 1'b1;
    send(1'b1, 32'hC, 5'd6, 32'h208);
    drain_all();

    // Flush while full with an incoming beat
    m_if.out_ready = 1'b0;
    send(1'b1, 32'hE, 5'd7, 32'h300);
    send(1'b1, 32'hF, 5'd8, 32'h304);
    set_in(1'b1, 1'b1, 32'hD, 5'd9, 32'h308);
    m_if.flush = 1'b1;
    cycle();
    m_if.flush = 1'b0;
    m_if.in_valid = 1'b0;
    cycle();

    // Flush at occupancy 1 while an accept would otherwise happen
    send(1'b1, 32'h1E, 5'd7, 32'h310);
    set_in(1'b1, 1'b1, 32'hD, 5'd9, 32'h314);
    m_if.flush = 1'b1;
    cycle();
    m_if.flush = 1'b0;
    m_if.in_valid = 1'b0;
    send(1'b1, 32'h44, 5'd10, 32'h318);
    drain_all();

    // Write to r0 is suppressed but data still carried; full-width PC
    m_if.out_ready = 1'b0;
    send(1'b1, 32'h55, 5'd0, 32'h400);
    send(1'b1, 32'h66, 5'd31, 32'hDEADBEEF);
    drain_all();

    // Main instance must not capture on a rising edge
    m_if.out_ready = 1'b0;
    set_in(1'b1, 1'b1, 32'h77, 5'd2, 32'hDEADBEEF);
    @(posedge Clk); #1;
    chk("neg_no_posedge_occ", m_if.occupancy, 2'd0);
    cycle();
    m_if.in_valid = 1'b0;
    drain_all();

    // Mid-stream asynchronous reset with both entries held
    m_if.out_ready = 1'b0;
    send(1'b1, 32'h88, 5'd1, 32'h500);
    send(1'b1, 32'h99, 5'd1, 32'h504);
    chk("pre_reset_occ", m_if.occupancy, 2'd2);
    #1 Reset = 1'b1;
    #1 chk_reset_state("mid");
    exp_q.delete();
    #1 Reset = 1'b0;
    @(negedge Clk); #1;
    cycle();

    // Rising-edge instance, no zero suppression
    @(posedge Clk); #1;
    p_if.in_valid = 1'b1; p_if.regwrite_in = 1'b1; p_if.wdata_in = 32'h77;
    p_if.wreg_in = 5'd0;  p_if.pc_in = 32'hDEADBEEF;
    @(negedge Clk); #1;
    chk("pos_no_negedge_valid", p_if.out_valid, 1'b0);
    chk("pos_no_negedge_occ", p_if.occupancy, 2'd0);
    @(posedge Clk); #1;
    p_if.in_valid = 1'b0;
    chk("pos_valid", p_if.out_valid, 1'b1);
    chk("pos_pc", p_if.pc_out, 32'hDEADBEEF);
    chk("pos_wdata", p_if.wdata_out, 32'h77);
    chk("pos_regwrite_r0", p_if.regwrite_out, 1'b1);
    $display("tb: pos-edge capture wdata=0x%0h pc=0x%0h rw=%0b",
             p_if.wdata_out, p_if.pc_out, p_if.regwrite_out);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
